// File: rtl/store_write_buffer_if.sv
// Store write buffer bus bundle.
// Groups the pipeline store port, the load-forwarding port and the RAM write port
// so the buffer and its neighbours share one connection.
//   master : pipeline/RAM side (drives stores, load address, mem_busy)
//   slave  : the buffer itself (drives ready, forwarding result, RAM write, status)
interface store_write_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // Store port
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  // Load forwarding port
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  // RAM write port
  logic          mem_busy;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  // Status
  logic [CW-1:0] count;
  logic          empty;

  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_busy,
    input  st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wdata, count, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_busy,
    output st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wdata, count, empty
  );
endinterface

// File: rtl/store_write_buffer.sv
// Store write buffer between the EXE/MEM boundary and the data-RAM write port.
// Stores are posted into a circular FIFO and drained in order whenever the RAM port
// is free; younger loads get the youngest matching pending store forwarded.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : store_write_buffer_if.slave (store, forwarding, RAM write, status)
module store_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  store_write_buffer_if.slave   bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = AW - 2;

  logic [WW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             w_empty;
  logic             w_ready;
  logic             w_accept;
  logic             w_drain;
  logic             w_ld_hit;
  logic [DW-1:0]    w_ld_data;
  logic [PW-1:0]    w_idx;
  logic             w_unused;

  // Ready depends on registered count only: a same-cycle drain never frees a slot early.
  assign w_empty  = (r_count == '0);
  assign w_ready  = (r_count != CW'(DEPTH));
  assign w_accept = bus.st_valid & w_ready;
  assign w_drain  = ~w_empty & ~bus.mem_busy;

  // Pointer, count and valid bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_accept) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      unique case ({w_accept, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload storage; validity is tracked separately so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr[r_tail] <= bus.st_addr[AW-1:2];
      r_data[r_tail] <= bus.st_data;
    end
  end

  // Forwarding: walk oldest to youngest so the youngest match is the last one kept.
  always_comb begin
    w_ld_hit  = 1'b0;
    w_ld_data = '0;
    w_idx     = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      w_idx = r_head + PW'(k);
      if (r_valid[w_idx] && (r_addr[w_idx] == bus.ld_addr[AW-1:2])) begin
        w_ld_hit  = 1'b1;
        w_ld_data = r_data[w_idx];
      end
    end
  end

  assign bus.st_ready  = w_ready;
  assign bus.empty     = w_empty;
  assign bus.count     = r_count;
  assign bus.mem_we    = w_drain;
  assign bus.mem_addr  = {r_addr[r_head], 2'b00};
  assign bus.mem_wdata = r_data[r_head];
  assign bus.ld_hit    = w_ld_hit;
  assign bus.ld_data   = w_ld_data;

  // Byte-offset bits are architecturally ignored for word accesses.
  assign w_unused = &{1'b0, bus.st_addr[1:0], bus.ld_addr[1:0]};
endmodule

// File: tb/tb_store_write_buffer.sv
// Testbench for store_write_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_store_write_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  store_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bif ();

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of pending stores.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      bit dr, ac;
      dr = (q.size() != 0) && !bif.mem_busy;
      ac = bif.st_valid && (q.size() != DEPTH);
      if (dr) void'(q.pop_front());
      if (ac) q.push_back('{wa: bif.st_addr[31:2], d: bif.st_data});
    end
  end

  // Record what the DUT actually hands to the RAM.
  always @(posedge clk) begin
    if (!rst && bif.mem_we) begin
      log_a.push_back(bif.mem_addr);
      log_d.push_back(bif.mem_wdata);
    end
  end

  // Per-cycle comparison against the model, after inputs have settled.
  always @(negedge clk) begin
    bit          hit;
    logic [31:0] hd;
    #2;
    hit = 1'b0;
    hd  = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].wa == bif.ld_addr[31:2]) begin
        hit = 1'b1;
        hd  = q[i].d;
        break;
      end
    end
    chk("m_count", 64'(bif.count), 64'(q.size()));
    chk("m_ready", 64'(bif.st_ready), 64'(q.size() != DEPTH));
    chk("m_empty", 64'(bif.empty), 64'(q.size() == 0));
    chk("m_we", 64'(bif.mem_we), 64'((q.size() != 0) && !bif.mem_busy));
    if (q.size() != 0) begin
      chk("m_addr", 64'(bif.mem_addr), 64'({q[0].wa, 2'b00}));
      chk("m_wdata", 64'(bif.mem_wdata), 64'(q[0].d));
    end
    chk("m_hit", 64'(bif.ld_hit), 64'(hit));
    chk("m_ldata", 64'(bif.ld_data), 64'(hd));
  end

  // Present inputs for one cycle; literal checks follow at +3.
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic busy, input logic [31:0] la);
    @(negedge clk);
    bif.st_valid = v;
    bif.st_addr  = a;
    bif.st_data  = d;
    bif.mem_busy = busy;
    bif.ld_addr  = la;
    #3;
  endtask

  logic [31:0] ea [4];
  int          base;

  initial begin
    bif.st_valid = 1'b0;
    bif.st_addr  = '0;
    bif.st_data  = '0;
    bif.mem_busy = 1'b0;
    bif.ld_addr  = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_count", 64'(bif.count), 64'd0);
    chk("rst_ready", 64'(bif.st_ready), 64'd1);
    chk("rst_empty", 64'(bif.empty), 64'd1);
    chk("rst_we", 64'(bif.mem_we), 64'd0);
    chk("rst_hit", 64'(bif.ld_hit), 64'd0);
    chk("rst_ldata", 64'(bif.ld_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk("idle_ready", 64'(bif.st_ready), 64'd1);
    chk("idle_we", 64'(bif.mem_we), 64'd0);

    // Single store drains one cycle after acceptance.
    cyc(1, 32'h10, 32'hAAAA0001, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t2_we", 64'(bif.mem_we), 64'd1);
    chk("t2_addr", 64'(bif.mem_addr), 64'h10);
    chk("t2_wdata", 64'(bif.mem_wdata), 64'hAAAA0001);
    cyc(0, 0, 0, 0, 0);
    chk("t2_empty", 64'(bif.empty), 64'd1);

    // Fill while RAM busy, overflow store ignored, then in-order drain.
    ea = '{32'h4, 32'h8, 32'hC, 32'h10};
    for (int i = 0; i < 4; i++) cyc(1, ea[i], 32'(i + 1), 1, 0);
    cyc(1, 32'h99C, 32'hDEAD, 1, 0);
    chk("t3_count", 64'(bif.count), 64'd4);
    chk("t3_ready", 64'(bif.st_ready), 64'd0);
    cyc(0, 0, 0, 1, 0);
    chk("t3_count_hold", 64'(bif.count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("t3_we", 64'(bif.mem_we), 64'd1);
      chk("t3_addr", 64'(bif.mem_addr), 64'(ea[i]));
      chk("t3_wdata", 64'(bif.mem_wdata), 64'(i + 1));
    end
    cyc(0, 0, 0, 0, 0);
    chk("t3_done", 64'(bif.count), 64'd0);

    // Full buffer with a same-cycle drain does not accept.
    for (int i = 0; i < 4; i++) cyc(1, 32'h100 + 32'(4 * i), 32'h11 * 32'(i + 1), 1, 0);
    cyc(1, 32'h200, 32'h55, 0, 0);
    chk("t4_ready", 64'(bif.st_ready), 64'd0);
    chk("t4_we", 64'(bif.mem_we), 64'd1);
    cyc(0, 0, 0, 1, 0);
    chk("t4_count", 64'(bif.count), 64'd3);
    chk("t4_head", 64'(bif.mem_addr), 64'h104);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t4_done", 64'(bif.empty), 64'd1);

    // Forwarding: youngest match wins, byte offset ignored.
    cyc(1, 32'h20, 32'd1, 1, 0);
    cyc(1, 32'h20, 32'd2, 1, 0);
    cyc(0, 0, 0, 1, 32'h22);
    chk("t5_hit", 64'(bif.ld_hit), 64'd1);
    chk("t5_data", 64'(bif.ld_data), 64'd2);
    cyc(0, 0, 0, 1, 32'h24);
    chk("t5_miss", 64'(bif.ld_hit), 64'd0);
    chk("t5_miss_d", 64'(bif.ld_data), 64'd0);
    cyc(1, 32'h24, 32'd7, 1, 32'h24);
    chk("t5_same_cyc", 64'(bif.ld_hit), 64'd0);
    cyc(0, 0, 0, 0, 32'h20);
    chk("t5_drain_fwd", 64'(bif.ld_hit), 64'd1);
    chk("t5_drain_fwd_d", 64'(bif.ld_data), 64'd2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    chk("t5_done", 64'(bif.empty), 64'd1);

    // Steady stream: one in, one out per cycle, pointers wrap.
    base = log_a.size();
    for (int i = 0; i < 10; i++) begin
      cyc(1, 32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 0, 0);
      if (i > 0) begin
        chk("t6_count", 64'(bif.count), 64'd1);
        chk("t6_addr", 64'(bif.mem_addr), 64'(32'h300 + 32'(4 * (i - 1))));
      end
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t6_nwr", 64'(log_a.size() - base), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (base + i < log_a.size()) begin
        chk("t6_ram_a", 64'(log_a[base + i]), 64'(32'h300 + 32'(4 * i)));
        chk("t6_ram_d", 64'(log_d[base + i]), 64'(32'h1000 + 32'(i)));
      end
    end

    // Reset asserted mid-drain with three entries.
    for (int i = 0; i < 3; i++) cyc(1, 32'h400 + 32'(4 * i), 32'(i), 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t1_pre_we", 64'(bif.mem_we), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("t1_count", 64'(bif.count), 64'd0);
    chk("t1_we", 64'(bif.mem_we), 64'd0);
    chk("t1_ready", 64'(bif.st_ready), 64'd1);
    chk("t1_empty", 64'(bif.empty), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
